pc_ctrl: RTL

Parametrised program-counter unit with an on-chip debug controller: generates the fetch PC (reset vector, sequential increment, branch, CP0 exception redirect, pipeline stall) and adds NUM_BP programmable hardware breakpoints, an external halt request, resume, and N-instruction single-step. It sits at the front of the fetch stage, drives the instruction-memory address, and feeds `stop_o` into the stall controller so the whole pipeline freezes while debugging.

---
 rtl/pc_ctrl_if.sv | 36 +++
 rtl/pc_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - fetch/debug signal bundle between the debug host and the PC unit
interface pc_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int BPI_W  = 2
);
  logic [5:0]        stall;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_address_i;
  logic              cp0_branch_flag;
  logic [ADDR_W-1:0] cp0_branch_addr;
  logic              bp_we;
  logic [BPI_W-1:0]  bp_idx;
  logic [ADDR_W-1:0] bp_addr;
  logic              bp_en;
  logic              halt_req;
  logic              resume;
  logic [7:0]        step_cnt;
  logic [ADDR_W-1:0] pc;
  logic              stop_o;
  logic              halted;
  logic              has_break;
  logic [BPI_W-1:0]  bp_hit_idx;
  logic [1:0]        halt_cause;

  modport master (
    output stall, branch_flag_i, branch_target_address_i, cp0_branch_flag, cp0_branch_addr,
           bp_we, bp_idx, bp_addr, bp_en, halt_req, resume, step_cnt,
    input  pc, stop_o, halted, has_break, bp_hit_idx, halt_cause
  );

  modport slave (
    input  stall, branch_flag_i, branch_target_address_i, cp0_branch_flag, cp0_branch_addr,
           bp_we, bp_idx, bp_addr, bp_en, halt_req, resume, step_cnt,
    output pc, stop_o, halted, has_break, bp_hit_idx, halt_cause
  );
endinterface

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch PC generator with breakpoints, halt/resume and single-step
module pc_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC00000,
  parameter int                INC      = 4,
  parameter int                NUM_BP   = 4,
  localparam int               BPI_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input logic       clk,
  input logic       rst,
  pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_STEP = 2'd1, S_HALT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              skip_q, skip_d;
  logic              has_break_q, has_break_d;
  logic [BPI_W-1:0]  bp_hit_idx_q, bp_hit_idx_d, hit_idx;
  logic [1:0]        cause_q, cause_d;
  logic              hit, active, advance, step_done, stop;
  logic              stall_unused;

  // only stall[0] concerns the fetch PC; the rest belongs to later stages
  assign stall_unused = ^bus.stall[5:1];

  // breakpoint slot storage; written in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
      bp_en_q <= '0;
    end else if (bus.bp_we && (int'(bus.bp_idx) < NUM_BP)) begin
      bp_addr_q[bus.bp_idx] <= bus.bp_addr;
      bp_en_q[bus.bp_idx]   <= bus.bp_en;
    end
  end

  // match current pc against enabled slots, lowest index wins; skip masks the resumed-at address
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == pc_q)) begin
        hit     = 1'b1;
        hit_idx = BPI_W'(i);
      end
    end
    if (skip_q) hit = 1'b0;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // next state: cp0 redirect outranks halting, hit/halt_req outrank the step counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN, S_STEP: begin
        if (!bus.cp0_branch_flag && (hit || bus.halt_req)) state_d = S_HALT;
        else if (step_done)                                state_d = S_HALT;
      end
      S_HALT: begin
        if (bus.resume && !bus.halt_req) state_d = (bus.step_cnt == 8'd0) ? S_RUN : S_STEP;
      end
      default: state_d = S_RUN;
    endcase
  end

  // outputs: freeze request and advance qualification
  always_comb begin
    active    = (state_q != S_HALT);
    advance   = active && (bus.cp0_branch_flag || (!hit && !bus.halt_req && !bus.stall[0]));
    step_done = (state_q == S_STEP) && advance && (cnt_q == 8'd1);
    stop      = !active || (!bus.cp0_branch_flag && (hit || bus.halt_req));
  end

  // datapath next values: pc, step counter, skip and debug status
  always_comb begin
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    skip_d       = skip_q;
    has_break_d  = has_break_q;
    bp_hit_idx_d = bp_hit_idx_q;
    cause_d      = cause_q;
    if (active) begin
      if (bus.cp0_branch_flag)
        pc_d = bus.cp0_branch_addr;
      else if (advance)
        pc_d = bus.branch_flag_i ? bus.branch_target_address_i : pc_q + ADDR_W'(INC);
      if (advance) begin
        skip_d = 1'b0;
        if (state_q == S_STEP) cnt_d = cnt_q - 8'd1;
      end
      if (!bus.cp0_branch_flag && hit) begin
        has_break_d  = 1'b1;
        bp_hit_idx_d = hit_idx;
        cause_d      = 2'b01;
      end else if (!bus.cp0_branch_flag && bus.halt_req) begin
        cause_d = 2'b10;
      end else if (step_done) begin
        cause_d = 2'b11;
      end
    end else if (bus.resume && !bus.halt_req) begin
      skip_d      = 1'b1;
      cnt_d       = bus.step_cnt;
      has_break_d = 1'b0;
      cause_d     = 2'b00;
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      cnt_q        <= 8'd0;
      skip_q       <= 1'b0;
      has_break_q  <= 1'b0;
      bp_hit_idx_q <= '0;
      cause_q      <= 2'b00;
    end else begin
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      skip_q       <= skip_d;
      has_break_q  <= has_break_d;
      bp_hit_idx_q <= bp_hit_idx_d;
      cause_q      <= cause_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.stop_o     = stop;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.has_break  = has_break_q;
  assign bus.bp_hit_idx = bp_hit_idx_q;
  assign bus.halt_cause = cause_q;

endmodule
